// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch initiator that owns the PC, drives the ROM and fills IF/ID
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          INST_MEM_LOG2 = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        addr_err_o,
    output logic [1:0]  fetch_state_o,
    output logic [31:0] fetch_count_o
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;

    // ROM word index is addr[INST_MEM_LOG2+1:2], so the depth must fit a 32-bit byte address
    if (INST_MEM_LOG2 < 1 || INST_MEM_LOG2 > 30) begin : g_bad_depth
        $error("if_fetch_unit: INST_MEM_LOG2 out of range");
    end

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        err_next;
    logic [31:0] captured;
    logic        count_inc;
    logic [1:0]  state;
    logic [1:0]  state_next;

    assign rom_addr_o = pc;
    assign captured   = rom_ce_o ? rom_inst_i : 32'h0;

    // PC next-value selection: flush beats stall beats branch beats sequential fetch
    always_comb begin
        redirect        = flush_i | (~stall_i[0] & branch_flag_i);
        redirect_target = flush_i ? new_pc_i : branch_target_i;
        pc_next         = !rom_ce_o     ? pc :
                          redirect      ? {redirect_target[31:2], 2'b00} :
                          stall_i[0]    ? pc :
                                          pc + 32'd4;
        err_next        = rom_ce_o & redirect & (redirect_target[1:0] != 2'b00);
        count_inc       = rom_ce_o & ~flush_i & ~stall_i[1] & (fetch_count_o != 32'hFFFF_FFFF);
    end

    // ROM enable, PC and misaligned-redirect pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_ce_o   <= 1'b0;
            pc         <= RESET_PC;
            addr_err_o <= 1'b0;
        end else begin
            rom_ce_o   <= 1'b1;
            pc         <= pc_next;
            addr_err_o <= err_next;
        end
    end

    // IF/ID register: flush clears, IF-only stall inserts a bubble, full stall holds
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            id_pc_o   <= 32'h0;
            id_inst_o <= 32'h0;
        end else if (stall_i[1] && !stall_i[2]) begin
            id_pc_o   <= 32'h0;
            id_inst_o <= 32'h0;
        end else if (!stall_i[1]) begin
            id_pc_o   <= pc;
            id_inst_o <= captured;
        end
    end

    // Saturating count of real instructions handed to ID
    always_ff @(posedge clk) begin
        if (rst)
            fetch_count_o <= 32'h0;
        else if (count_inc)
            fetch_count_o <= fetch_count_o + 32'd1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next state: leaving reset always enables the ROM, flush overrides a PC stall
    always_comb begin
        state_next = (state == IDLE) ? RUN :
                     flush_i         ? RUN :
                     stall_i[0]      ? HOLD : RUN;
    end

    // FSM outputs
    always_comb begin
        fetch_state_o = state;
    end
endmodule
